compare_stage: RTL and testbench

- Upstream feeder for state_machine: checks an incoming sample stream against a small programmable expected-pattern table.
- Drives the state machine's compare_result input and honours its hold and error outputs for back-pressure and resynchronisation.
- Keeps a saturating mismatch count for debug/status.

---
 rtl/compare_stage_if.sv | 32 +++
 rtl/compare_stage.sv | 55 +++++
 tb/tb_compare_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/compare_stage_if.sv
// Sample/pattern/status bundle between compare_stage and its driver.
// The slave modport is the compare_stage side; master is the feeding/observing side.
interface compare_stage_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAT_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  localparam int unsigned IDX_WIDTH = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;

  logic                  pat_wr_en;
  logic [IDX_WIDTH-1:0]  pat_wr_addr;
  logic [DATA_WIDTH-1:0] pat_wr_data;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  hold;
  logic                  error;
  logic                  data_ready;
  logic                  compare_result;
  logic                  result_valid;
  logic [IDX_WIDTH-1:0]  pattern_index;
  logic [CNT_WIDTH-1:0]  mismatch_count;

  modport master (
    output pat_wr_en, pat_wr_addr, pat_wr_data, data_valid, data_in, hold, error,
    input  data_ready, compare_result, result_valid, pattern_index, mismatch_count
  );

  modport slave (
    input  pat_wr_en, pat_wr_addr, pat_wr_data, data_valid, data_in, hold, error,
    output data_ready, compare_result, result_valid, pattern_index, mismatch_count
  );
endinterface

// File: rtl/compare_stage.sv
// Checks an incoming sample stream against a small programmable pattern table,
// feeding a level compare_result to the downstream state machine.
module compare_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAT_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  compare_stage_if.slave   bus
);
  localparam int unsigned IDX_WIDTH = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] pat_q [PAT_DEPTH];
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  result_q;
  logic                  valid_q;
  logic                  ready_c;
  logic                  accept_c;
  logic                  match_c;

  assign ready_c  = !bus.hold && !bus.error && !reset;
  assign accept_c = bus.data_valid && ready_c;
  // Compare reads the table before any same-edge write lands.
  assign match_c  = (bus.data_in == pat_q[idx_q]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PAT_DEPTH; i++) pat_q[i] <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      result_q <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      if (bus.pat_wr_en) pat_q[bus.pat_wr_addr] <= bus.pat_wr_data;
      valid_q <= accept_c;
      if (accept_c) begin
        result_q <= match_c;
        idx_q    <= idx_q + IDX_WIDTH'(1);
        if (!match_c && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end else if (bus.error) begin
        // Resync to the start of the table; hold cannot block this.
        idx_q <= '0;
      end
    end
  end

  assign bus.data_ready     = ready_c;
  assign bus.compare_result = result_q;
  assign bus.result_valid   = valid_q;
  assign bus.pattern_index  = idx_q;
  assign bus.mismatch_count = cnt_q;
endmodule

// File: tb/tb_compare_stage.sv
// Scoreboard bench for compare_stage: two instances (8-bit and 2-bit counters)
// share stimulus; a reference model predicts results, a monitor checks them.
module tb_compare_stage;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    bit match;
    int cnt;
  } exp_t;

  logic clk;
  logic reset;

  compare_stage_if #(.DATA_WIDTH(DW), .PAT_DEPTH(DEPTH), .CNT_WIDTH(8)) bus_a ();
  compare_stage_if #(.DATA_WIDTH(DW), .PAT_DEPTH(DEPTH), .CNT_WIDTH(2)) bus_b ();

  compare_stage #(.DATA_WIDTH(DW), .PAT_DEPTH(DEPTH), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  compare_stage #(.DATA_WIDTH(DW), .PAT_DEPTH(DEPTH), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Reference model state
  int pat[DEPTH];
  int idx;
  int cnt;
  bit last;
  bit model_ok = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: every result pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("result_valid", 32'(bus_a.result_valid), (exp_q.size() != 0) ? 1 : 0);
      chk("result_valid_b", 32'(bus_b.result_valid), (exp_q.size() != 0) ? 1 : 0);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus_a.result_valid === 1'b1) begin
          chk("compare_result", 32'(bus_a.compare_result), int'(e.match));
          chk("compare_result_b", 32'(bus_b.compare_result), int'(e.match));
          chk("mismatch_count_res", 32'(bus_a.mismatch_count), sat(e.cnt, 255));
        end
      end
    end
  end

  task automatic drive(input bit r, input bit we, input int wa, input int wd,
                       input bit v, input int d, input bit h, input bit e);
    reset = r;
    bus_a.pat_wr_en = we;       bus_b.pat_wr_en = we;
    bus_a.pat_wr_addr = 2'(wa); bus_b.pat_wr_addr = 2'(wa);
    bus_a.pat_wr_data = 8'(wd); bus_b.pat_wr_data = 8'(wd);
    bus_a.data_valid = v;       bus_b.data_valid = v;
    bus_a.data_in = 8'(d);      bus_b.data_in = 8'(d);
    bus_a.hold = h;             bus_b.hold = h;
    bus_a.error = e;            bus_b.error = e;
  endtask

  // One clock of stimulus: check current state, then advance the model.
  task automatic step(input bit r, input bit we, input int wa, input int wd,
                      input bit v, input int d, input bit h, input bit e);
    bit acc;
    bit m;
    @(negedge clk);
    #1;
    drive(r, we, wa, wd, v, d, h, e);
    #1;
    chk("data_ready", 32'(bus_a.data_ready), (!h && !e && !r) ? 1 : 0);
    if (model_ok) begin
      chk("pattern_index", 32'(bus_a.pattern_index), idx);
      chk("mismatch_count", 32'(bus_a.mismatch_count), sat(cnt, 255));
      chk("mismatch_count_sat2", 32'(bus_b.mismatch_count), sat(cnt, 3));
      chk("compare_level", 32'(bus_a.compare_result), int'(last));
    end
    acc = v && !h && !e && !r;
    if (r) begin
      foreach (pat[i]) pat[i] = 0;
      idx = 0;
      cnt = 0;
      last = 1'b1;
      exp_q.delete();
      model_ok = 1'b1;
    end else begin
      if (acc) begin
        m = (d == pat[idx]);
        last = m;
        if (!m) cnt++;
        exp_q.push_back('{match: m, cnt: cnt});
        idx = (idx + 1) % DEPTH;
      end else if (e) begin
        idx = 0;
      end
      if (we) pat[wa] = wd;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(input int d);
    step(0, 0, 0, 0, 1, d, 0, 0);
  endtask

  task automatic fill();
    step(0, 1, 0, 8'h11, 0, 0, 0, 0);
    step(0, 1, 1, 8'h22, 0, 0, 0, 0);
    step(0, 1, 2, 8'h33, 0, 0, 0, 0);
    step(0, 1, 3, 8'h44, 0, 0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    fill();

    // Back-to-back matching stream with index wrap
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h11);
    idle();

    // Resync, then match / mismatch / match and idle level hold
    step(0, 0, 0, 0, 0, 0, 0, 1);
    send(8'h11); send(8'h99); send(8'h33);
    idle(); idle(); idle();

    // Hold with valid asserted freezes everything
    step(0, 0, 0, 0, 1, 8'h44, 1, 0);
    step(0, 0, 0, 0, 1, 8'h44, 1, 0);
    step(0, 0, 0, 0, 1, 8'h44, 1, 0);
    send(8'h44);
    idle();

    // Advance to index 2, error pulse, resume from 0
    send(8'h22);
    send(8'h33);
    step(0, 0, 0, 0, 1, 8'h44, 0, 1);
    send(8'h11);
    idle();

    // Hold and error together: index resets, nothing accepted
    send(8'h22);
    step(0, 0, 0, 0, 1, 8'h33, 1, 1);
    send(8'h11);
    idle();

    // Saturation from a fresh reset (2-bit instance tops out at 3)
    step(1, 0, 0, 0, 1, 8'h11, 0, 0);
    fill();
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    idle();

    // Same-edge write to current index uses the old entry
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 8'h55, 1, 8'h11, 0, 0);
    send(8'h22); send(8'h33); send(8'h44);
    send(8'h55);
    idle();

    // Reset mid-stream clears the table to zero
    send(8'h66);
    step(1, 0, 0, 0, 1, 8'h22, 0, 0);
    send(8'h00);
    send(8'h01);
    idle();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      bit r, we, v, h, e;
      int wa, wd, d;
      r  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 4) == 0);
      wa = $urandom_range(0, DEPTH - 1);
      wd = $urandom_range(0, 255);
      v  = ($urandom_range(0, 3) != 0);
      h  = ($urandom_range(0, 5) == 0);
      e  = ($urandom_range(0, 9) == 0);
      d  = ($urandom_range(0, 1) == 1) ? pat[idx] : $urandom_range(0, 255);
      step(r, we, wa, wd, v, d, h, e);
    end

    idle(); idle(); idle();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
